// File: rtl/csr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csr_arbiter                                                  |
// | Description : Round-robin arbiter between the pipeline (P) and debug (D)   |
// |               CSR request ports. Issues one single-cycle CSR file access   |
// |               per grant and returns the pre-access value with a one-cycle  |
// |               response pulse. Writes to read-only space (adr[11:10]==11)   |
// |               are suppressed and flagged.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csr_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p_req,
    input  logic [1:0]  i_p_op,
    input  logic [11:0] i_p_adr,
    input  logic [31:0] i_p_data,
    output logic        o_p_gnt,
    output logic        o_p_rvalid,
    output logic [31:0] o_p_rdata,
    output logic        o_p_err,
    input  logic        i_d_req,
    input  logic [1:0]  i_d_op,
    input  logic [11:0] i_d_adr,
    input  logic [31:0] i_d_data,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic        o_csr_rd,
    output logic        o_csr_wr,
    output logic        o_csr_set,
    output logic        o_csr_clr,
    output logic [11:0] o_csr_adr,
    output logic [31:0] o_csr_wr_data,
    input  logic [31:0] i_csr_rd_data
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_SET   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      r_state_q,   w_state_d;
    logic        r_last_d_q,  w_last_d_d;   // 1: debug port was served last
    logic        r_sel_d_q,   w_sel_d_d;    // 1: current access belongs to debug port
    logic        r_err_q,     w_err_d;      // current access targets read-only space
    logic [11:0] r_adr_q,     w_adr_d;
    logic [31:0] r_wdata_q,   w_wdata_d;
    logic        r_p_gnt_q,   w_p_gnt_d;
    logic        r_d_gnt_q,   w_d_gnt_d;
    logic        r_rd_q,      w_rd_d;
    logic        r_wr_q,      w_wr_d;
    logic        r_set_q,     w_set_d;
    logic        r_clr_q,     w_clr_d;
    logic        r_p_rvalid_q, w_p_rvalid_d;
    logic        r_d_rvalid_q, w_d_rvalid_d;
    logic        r_p_err_q,   w_p_err_d;
    logic        r_d_err_q,   w_d_err_d;
    logic [31:0] r_p_rdata_q, w_p_rdata_d;
    logic [31:0] r_d_rdata_q, w_d_rdata_d;

    logic        w_p_win;
    logic        w_d_win;
    logic [1:0]  w_win_op;
    logic [11:0] w_win_adr;
    logic [31:0] w_win_data;
    logic        w_win_err;
    logic [31:0] w_acc_rdata;

    // Arbitration: a lone requester wins; on a tie the port not served last wins
    always_comb begin
        w_p_win    = i_p_req & (~i_d_req | r_last_d_q);
        w_d_win    = i_d_req & ~w_p_win;
        w_win_op   = w_d_win ? i_d_op   : i_p_op;
        w_win_adr  = w_d_win ? i_d_adr  : i_p_adr;
        w_win_data = w_d_win ? i_d_data : i_p_data;
        w_win_err  = (w_win_op != c_OP_READ) && (w_win_adr[11:10] == 2'b11);
        w_acc_rdata = r_err_q ? 32'h0 : i_csr_rd_data;
    end

    // Next-state logic; pulses default low, latched data defaults to hold
    always_comb begin
        w_state_d    = r_state_q;
        w_last_d_d   = r_last_d_q;
        w_sel_d_d    = r_sel_d_q;
        w_err_d      = r_err_q;
        w_adr_d      = r_adr_q;
        w_wdata_d    = r_wdata_q;
        w_p_rdata_d  = r_p_rdata_q;
        w_d_rdata_d  = r_d_rdata_q;
        w_p_gnt_d    = 1'b0;
        w_d_gnt_d    = 1'b0;
        w_rd_d       = 1'b0;
        w_wr_d       = 1'b0;
        w_set_d      = 1'b0;
        w_clr_d      = 1'b0;
        w_p_rvalid_d = 1'b0;
        w_d_rvalid_d = 1'b0;
        w_p_err_d    = 1'b0;
        w_d_err_d    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_p_win || w_d_win) begin
                    w_sel_d_d  = w_d_win;
                    w_last_d_d = w_d_win;
                    w_adr_d    = w_win_adr;
                    w_wdata_d  = w_win_data;
                    w_err_d    = w_win_err;
                    w_p_gnt_d  = w_p_win;
                    w_d_gnt_d  = w_d_win;
                    // Strobes are registered here so they appear exactly in ISSUE
                    if (!w_win_err) begin
                        case (w_win_op)
                            c_OP_READ:  w_rd_d  = 1'b1;
                            c_OP_WRITE: w_wr_d  = 1'b1;
                            c_OP_SET:   w_set_d = 1'b1;
                            c_OP_CLEAR: w_clr_d = 1'b1;
                        endcase
                    end
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The CSR file updates on this same edge, so this is the pre-access value
                if (r_sel_d_q) begin
                    w_d_rdata_d  = w_acc_rdata;
                    w_d_rvalid_d = 1'b1;
                    w_d_err_d    = r_err_q;
                end else begin
                    w_p_rdata_d  = w_acc_rdata;
                    w_p_rvalid_d = 1'b1;
                    w_p_err_d    = r_err_q;
                end
                w_state_d = S_RESP;
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q    <= S_IDLE;
            r_last_d_q   <= 1'b1;
            r_sel_d_q    <= 1'b0;
            r_err_q      <= 1'b0;
            r_adr_q      <= 12'h0;
            r_wdata_q    <= 32'h0;
            r_p_gnt_q    <= 1'b0;
            r_d_gnt_q    <= 1'b0;
            r_rd_q       <= 1'b0;
            r_wr_q       <= 1'b0;
            r_set_q      <= 1'b0;
            r_clr_q      <= 1'b0;
            r_p_rvalid_q <= 1'b0;
            r_d_rvalid_q <= 1'b0;
            r_p_err_q    <= 1'b0;
            r_d_err_q    <= 1'b0;
            r_p_rdata_q  <= 32'h0;
            r_d_rdata_q  <= 32'h0;
        end else begin
            r_state_q    <= w_state_d;
            r_last_d_q   <= w_last_d_d;
            r_sel_d_q    <= w_sel_d_d;
            r_err_q      <= w_err_d;
            r_adr_q      <= w_adr_d;
            r_wdata_q    <= w_wdata_d;
            r_p_gnt_q    <= w_p_gnt_d;
            r_d_gnt_q    <= w_d_gnt_d;
            r_rd_q       <= w_rd_d;
            r_wr_q       <= w_wr_d;
            r_set_q      <= w_set_d;
            r_clr_q      <= w_clr_d;
            r_p_rvalid_q <= w_p_rvalid_d;
            r_d_rvalid_q <= w_d_rvalid_d;
            r_p_err_q    <= w_p_err_d;
            r_d_err_q    <= w_d_err_d;
            r_p_rdata_q  <= w_p_rdata_d;
            r_d_rdata_q  <= w_d_rdata_d;
        end
    end

    assign o_p_gnt       = r_p_gnt_q;
    assign o_p_rvalid    = r_p_rvalid_q;
    assign o_p_rdata     = r_p_rdata_q;
    assign o_p_err       = r_p_err_q;
    assign o_d_gnt       = r_d_gnt_q;
    assign o_d_rvalid    = r_d_rvalid_q;
    assign o_d_rdata     = r_d_rdata_q;
    assign o_d_err       = r_d_err_q;
    assign o_csr_rd      = r_rd_q;
    assign o_csr_wr      = r_wr_q;
    assign o_csr_set     = r_set_q;
    assign o_csr_clr     = r_clr_q;
    assign o_csr_adr     = r_adr_q;
    assign o_csr_wr_data = r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csr_arbiter                                               |
// | Description : Self-checking bench for csr_arbiter with a behavioural CSR   |
// |               file, directed table vectors, hand sequences and random      |
// |               rounds checked against a transaction-level model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_csr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_req, d_req;
    logic [1:0]  p_op, d_op;
    logic [11:0] p_adr, d_adr;
    logic [31:0] p_data, d_data;
    logic        o_p_gnt, o_p_rvalid, o_p_err;
    logic        o_d_gnt, o_d_rvalid, o_d_err;
    logic [31:0] o_p_rdata, o_d_rdata;
    logic        o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr;
    logic [11:0] o_csr_adr;
    logic [31:0] o_csr_wr_data;
    logic [31:0] csr_rd_data;

    logic [31:0] csr_mem [4096];   // behavioural CSR file
    logic [31:0] ref_mem [4096];   // transaction-level model state
    logic        mem_init;
    bit          last_d;           // model: debug port served last

    int n_vec;
    int n_err;

    csr_arbiter u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_p_req       (p_req),
        .i_p_op        (p_op),
        .i_p_adr       (p_adr),
        .i_p_data      (p_data),
        .o_p_gnt       (o_p_gnt),
        .o_p_rvalid    (o_p_rvalid),
        .o_p_rdata     (o_p_rdata),
        .o_p_err       (o_p_err),
        .i_d_req       (d_req),
        .i_d_op        (d_op),
        .i_d_adr       (d_adr),
        .i_d_data      (d_data),
        .o_d_gnt       (o_d_gnt),
        .o_d_rvalid    (o_d_rvalid),
        .o_d_rdata     (o_d_rdata),
        .o_d_err       (o_d_err),
        .o_csr_rd      (o_csr_rd),
        .o_csr_wr      (o_csr_wr),
        .o_csr_set     (o_csr_set),
        .o_csr_clr     (o_csr_clr),
        .o_csr_adr     (o_csr_adr),
        .o_csr_wr_data (o_csr_wr_data),
        .i_csr_rd_data (csr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        if (a == 12'h800)      return 32'h0000_00F0;
        else if (a == 12'hF00) return 32'h1357_2468;
        else                   return 32'hA500_0000 | a;
    endfunction

    // CSR file: combinational read, update on the clock edge
    assign csr_rd_data = csr_mem[o_csr_adr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(i);
        end else if (o_csr_wr) begin
            csr_mem[o_csr_adr] <= o_csr_wr_data;
        end else if (o_csr_set) begin
            csr_mem[o_csr_adr] <= csr_mem[o_csr_adr] | o_csr_wr_data;
        end else if (o_csr_clr) begin
            csr_mem[o_csr_adr] <= csr_mem[o_csr_adr] & ~o_csr_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected strobe vector {rd,wr,set,clr} for an access
    function automatic logic [3:0] strobe_of(input logic [1:0] op, input bit err);
        logic [3:0] one;
        one = 4'b1000;
        return err ? 4'b0000 : (one >> op);
    endfunction

    // Transaction-level model of one access
    function automatic void model_op(input logic [1:0] op, input logic [11:0] a,
                                     input logic [31:0] dt, output logic [31:0] rd,
                                     output bit er);
        er = (op != 2'b00) && (a[11:10] == 2'b11);
        rd = er ? 32'h0 : ref_mem[a];
        if (!er) begin
            case (op)
                2'b01:   ref_mem[a] = dt;
                2'b10:   ref_mem[a] = ref_mem[a] | dt;
                2'b11:   ref_mem[a] = ref_mem[a] & ~dt;
                default: ;
            endcase
        end
    endfunction

    // One arbitration round from IDLE using the currently driven request fields.
    // Starts and ends on a falling edge with the DUT idle.
    task automatic run_round(input bit pa, input bit da, input bit first_d,
                             input logic [31:0] prd, input bit perr,
                             input logic [31:0] drd, input bit derr);
        int pg, dg, last;
        logic [3:0] exp_st;
        pg = pa ? ((da && first_d) ? 4 : 1) : -10;
        dg = da ? ((pa && !first_d) ? 4 : 1) : -10;
        last = (pg > dg) ? pg : dg;
        if (last < 0) last = 0;
        p_req = pa;
        d_req = da;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            chk("p_gnt", o_p_gnt, c == pg);
            chk("d_gnt", o_d_gnt, c == dg);
            chk("p_rvalid", o_p_rvalid, c == pg + 1);
            chk("d_rvalid", o_d_rvalid, c == dg + 1);
            exp_st = 4'b0000;
            if (c == pg) exp_st = strobe_of(p_op, perr);
            if (c == dg) exp_st = strobe_of(d_op, derr);
            chk("strobes", {o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, exp_st);
            if (c == pg) begin
                chk("p_csr_adr", o_csr_adr, p_adr);
                chk("p_csr_wdata", o_csr_wr_data, p_data);
                p_req = 1'b0;
            end
            if (c == dg) begin
                chk("d_csr_adr", o_csr_adr, d_adr);
                chk("d_csr_wdata", o_csr_wr_data, d_data);
                d_req = 1'b0;
            end
            if (c == pg + 1) begin
                chk("p_rdata", o_p_rdata, prd);
                chk("p_err", o_p_err, perr);
            end else chk("p_err_low", o_p_err, 1'b0);
            if (c == dg + 1) begin
                chk("d_rdata", o_d_rdata, drd);
                chk("d_err", o_d_err, derr);
            end else chk("d_err_low", o_d_err, 1'b0);
        end
        if (pa && da) last_d = !first_d;
        else if (pa)  last_d = 1'b0;
        else if (da)  last_d = 1'b1;
    endtask

    typedef struct {
        bit pa; logic [1:0] pop; logic [11:0] padr; logic [31:0] pdat;
        bit da; logic [1:0] dop; logic [11:0] dadr; logic [31:0] ddat;
        bit first_d;
        logic [31:0] prd; bit perr;
        logic [31:0] drd; bit derr;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    function automatic logic [11:0] pick_adr();
        logic [11:0] off;
        off = 12'($urandom_range(0, 15));
        return ($urandom_range(0, 1) != 0) ? (12'h010 + off) : (12'hC10 + off);
    endfunction

    // Safety net against a DUT that stalls the bench
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pa, da, fd, perr, derr;
        logic [31:0] prd, drd;

        n_vec = 0; n_err = 0;
        rst_n = 1'b0; mem_init = 1'b1; last_d = 1'b1;
        p_req = 0; p_op = 0; p_adr = 0; p_data = 0;
        d_req = 0; d_op = 0; d_adr = 0; d_data = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

        // Reset state
        #1;
        chk("rst_gnt_rvalid_err", {o_p_gnt, o_d_gnt, o_p_rvalid, o_d_rvalid, o_p_err, o_d_err}, 0);
        chk("rst_strobes", {o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 4'b0000);
        chk("rst_p_rdata", o_p_rdata, 0);
        chk("rst_d_rdata", o_d_rdata, 0);
        chk("rst_csr_adr", o_csr_adr, 0);
        chk("rst_csr_wdata", o_csr_wr_data, 0);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        rst_n = 1'b1;

        // Directed vectors (expected values worked out by hand)
        tbl[0]  = '{1, 2'd1, 12'h200, 32'h1234_5678, 0, 2'd0, 12'h000, 32'h0, 0, 32'hA500_0200, 0, 32'h0, 0};
        tbl[1]  = '{1, 2'd0, 12'h200, 32'h0,         0, 2'd0, 12'h000, 32'h0, 0, 32'h1234_5678, 0, 32'h0, 0};
        tbl[2]  = '{1, 2'd2, 12'h800, 32'h0000_000F, 0, 2'd0, 12'h000, 32'h0, 0, 32'h0000_00F0, 0, 32'h0, 0};
        tbl[3]  = '{1, 2'd3, 12'h800, 32'h0000_00F0, 0, 2'd0, 12'h000, 32'h0, 0, 32'h0000_00FF, 0, 32'h0, 0};
        tbl[4]  = '{1, 2'd0, 12'h800, 32'h0,         0, 2'd0, 12'h000, 32'h0, 0, 32'h0000_000F, 0, 32'h0, 0};
        tbl[5]  = '{0, 2'd0, 12'h000, 32'h0, 1, 2'd1, 12'hF00, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0, 1};
        tbl[6]  = '{0, 2'd0, 12'h000, 32'h0, 1, 2'd0, 12'hF00, 32'h0,         0, 32'h0, 0, 32'h1357_2468, 0};
        tbl[7]  = '{1, 2'd1, 12'h201, 32'h1, 1, 2'd0, 12'h201, 32'h0,  0, 32'hA500_0201, 0, 32'h1, 0};
        tbl[8]  = '{1, 2'd0, 12'h201, 32'h0, 1, 2'd2, 12'h201, 32'h10, 0, 32'h1, 0, 32'h1, 0};
        tbl[9]  = '{0, 2'd0, 12'h000, 32'h0, 1, 2'd3, 12'hC00, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'h0, 1};
        tbl[10] = '{1, 2'd0, 12'hC00, 32'h0,      0, 2'd0, 12'h000, 32'h0, 0, 32'hA500_0C00, 0, 32'h0, 0};
        tbl[11] = '{1, 2'd2, 12'hFFF, 32'h1,      0, 2'd0, 12'h000, 32'h0, 0, 32'h0, 1, 32'h0, 0};
        tbl[12] = '{1, 2'd1, 12'h800, 32'h55, 1, 2'd0, 12'h800, 32'h0, 1, 32'h0000_000F, 0, 32'h0000_000F, 0};
        tbl[13] = '{1, 2'd0, 12'h800, 32'h0,  0, 2'd0, 12'h000, 32'h0, 0, 32'h0000_0055, 0, 32'h0, 0};
        for (int i = 0; i < NV; i++) begin
            p_op = tbl[i].pop; p_adr = tbl[i].padr; p_data = tbl[i].pdat;
            d_op = tbl[i].dop; d_adr = tbl[i].dadr; d_data = tbl[i].ddat;
            run_round(tbl[i].pa, tbl[i].da, tbl[i].first_d,
                      tbl[i].prd, tbl[i].perr, tbl[i].drd, tbl[i].derr);
        end

        // P arrives while D is in ISSUE: sampled only after D's response
        d_req = 1; d_op = 2'd0; d_adr = 12'h800; d_data = 0;
        @(negedge clk);
        chk("late_d_gnt", o_d_gnt, 1'b1);
        chk("late_d_strobe", {o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 4'b1000);
        d_req = 0;
        p_req = 1; p_op = 2'd0; p_adr = 12'h200; p_data = 0;
        @(negedge clk);
        chk("late_d_rvalid", o_d_rvalid, 1'b1);
        chk("late_d_rdata", o_d_rdata, 32'h55);
        chk("late_p_gnt_resp", o_p_gnt, 1'b0);
        @(negedge clk);
        chk("late_p_gnt_idle", o_p_gnt, 1'b0);
        @(negedge clk);
        chk("late_p_gnt", o_p_gnt, 1'b1);
        chk("late_p_strobe", {o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 4'b1000);
        p_req = 0;
        @(negedge clk);
        chk("late_p_rvalid", o_p_rvalid, 1'b1);
        chk("late_p_rdata", o_p_rdata, 32'h1234_5678);
        chk("late_d_rvalid_low", o_d_rvalid, 1'b0);
        @(negedge clk);
        last_d = 1'b0;

        // Reset asserted while a write is in ISSUE
        p_req = 1; p_op = 2'd1; p_adr = 12'h300; p_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("mid_gnt", o_p_gnt, 1'b1);
        chk("mid_strobe", {o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {o_p_gnt, o_d_gnt, o_p_rvalid, o_d_rvalid, o_p_err, o_d_err,
                             o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 0);
        chk("mid_rst_adr", o_csr_adr, 0);
        chk("mid_rst_wdata", o_csr_wr_data, 0);
        chk("mid_rst_p_rdata", o_p_rdata, 0);
        p_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        last_d = 1'b1;
        chk("mid_rst_write_dropped", csr_mem[12'h300], 32'hA500_0300);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {o_p_gnt, o_d_gnt, o_p_rvalid, o_d_rvalid,
                                   o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}, 0);
        end

        // Pointer back at "D served last": P wins the first tie
        p_op = 2'd0; p_adr = 12'h200; p_data = 0;
        d_op = 2'd0; d_adr = 12'h800; d_data = 0;
        run_round(1, 1, 0, 32'h1234_5678, 0, 32'h55, 0);

        // Random rounds against the transaction-level model
        for (int r = 0; r < 60; r++) begin
            pa = ($urandom_range(0, 3) != 0);
            da = ($urandom_range(0, 3) != 0);
            p_op = 2'($urandom_range(0, 3)); p_adr = pick_adr(); p_data = $urandom;
            d_op = 2'($urandom_range(0, 3)); d_adr = pick_adr(); d_data = $urandom;
            fd = pa && da && !last_d;
            prd = 0; perr = 0; drd = 0; derr = 0;
            if (fd) begin
                model_op(d_op, d_adr, d_data, drd, derr);
                model_op(p_op, p_adr, p_data, prd, perr);
            end else begin
                if (pa) model_op(p_op, p_adr, p_data, prd, perr);
                if (da) model_op(d_op, d_adr, d_data, drd, derr);
            end
            run_round(pa, da, fd, prd, perr, drd, derr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_arbiter.md
# csr_arbiter

Sequencer and two-port arbiter in front of the CSR file: it accepts CSR read/write/set/clear requests from the CPU pipeline (port P) and the debug unit (port D), grants one at a time with round-robin fairness, and drives the CSR file's strobe/address/data inputs for exactly one cycle per access. It registers the pre-access CSR value and returns it with a one-cycle response pulse. It also blocks writes to read-only CSR space.

## Interface
Parameters:
- none (CSR address 12 bits, data 32 bits, fixed)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_p_req  in  1  pipeline request; held high with op/adr/data stable until o_p_gnt
- i_p_op  in  2  00 read, 01 write, 10 set, 11 clear
- i_p_adr  in  12  CSR address
- i_p_data  in  32  write/set/clear operand
- o_p_gnt  out  1  one-cycle grant pulse; request is captured
- o_p_rvalid  out  1  one-cycle response pulse
- o_p_rdata  out  32  CSR value before the access; valid with o_p_rvalid
- o_p_err  out  1  illegal access; valid with o_p_rvalid
- i_d_req, i_d_op, i_d_adr, i_d_data, o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err: same widths and meaning for the debug port
- o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr  out  1 each  CSR file strobes; at most one high at a time
- o_csr_adr  out  12  CSR file address
- o_csr_wr_data  out  32  CSR file operand
- i_csr_rd_data  in  32  CSR file combinational read data

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE, no request: stay in IDLE. All strobes are 0.
- IDLE with request(s): pick the winner.
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins. The pointer resets to "D served last", so P wins the first tie.
  - At the edge: latch the winner's op/adr/data and winner id, update the pointer, set gnt for the winner, go to ISSUE.
- Illegal check at latch time: op != read and adr[11:10] == 2'b11. The result is latched as err.
- ISSUE:
  - o_csr_adr and o_csr_wr_data come from the latched values.
  - Legal access: assert exactly the one strobe matching op (read → o_csr_rd).
  - Illegal access: assert no strobe.
  - At the edge: capture i_csr_rd_data into the rdata register (0 if illegal), go to RESP. This is the pre-write value, because the CSR file writes on the same edge.
- RESP: assert rvalid, rdata and err for the winner only. The other port's rvalid/err stay 0 and its rdata holds. Next state is IDLE.
- Requests arriving during ISSUE/RESP are not sampled until IDLE.
- Requesters must deassert req in the cycle after gnt or a second access is issued. This is legal back-to-back use.
- Arithmetic: set/clear combine inside the CSR file. This block only forwards the operand; there is no width change.

## Timing
- Reset values:
  - state = IDLE, pointer = D.
  - gnt, rvalid, err = 0; rdata = 0.
  - All o_csr_* strobes = 0; o_csr_adr = 0, o_csr_wr_data = 0.
- Reset asserted mid-access (ISSUE or RESP): immediately clears all outputs. The CSR write of that access is dropped if reset covers the edge, and no response is produced.
- Latency:
  - Request seen in IDLE at edge N: gnt high in cycle N+1 (ISSUE, strobe high in the same cycle).
  - rvalid high in cycle N+2.
  - Next sample in cycle N+3.
- Throughput: one access per 3 cycles. Two ports continuously requesting alternate P, D, P, D.
- Strobes are high only in ISSUE. o_csr_adr/o_csr_wr_data hold the last latched values outside ISSUE.
- gnt, rvalid and all strobes are registered and glitch-free, and are never high for more than one cycle per access.

## Test plan
- Reset: drive i_rst_n low mid-ISSUE → all outputs 0 asynchronously; after release, state IDLE and no rvalid.
- P writes: 0x200 ← 0x12345678, then P reads 0x200 → write strobe 1 cycle in ISSUE with adr 0x200; read returns rdata 0x12345678, err 0, rvalid two cycles after request.
- Set then clear on 0x800:
  - Start at 0x0000_00F0, set 0x0F → rdata 0xF0.
  - Clear 0xF0 → rdata 0xFF.
  - Final read → 0x0F.
- Simultaneous P and D requests held continuously → grant order P, D, P, D; no strobe overlap; each rvalid goes only to its own port.
- D writes 0xF00 (read-only space) ← 0xDEADBEEF → no strobe asserted, rvalid with err 1 and rdata 0; a following read of 0xF00 returns the unchanged value with err 0.
- P requests while D's access is in ISSUE → P is sampled only after D's RESP; P's gnt comes 3 cycles after D's gnt.
